// File: rtl/blink_period_meter.sv
// Measures clk cycles between rising edges of an async input; classifies fast/slow, flags stalls.
// Latency: period/period_valid/fast/meas_count update 2 edges after blink_in is first sampled high.
// Backpressure: none; period_valid is a one-cycle strobe and is not held for a consumer.
module blink_period_meter #(
  parameter int CNT_W    = 28,
  parameter int FAST_MAX = 2**24,
  parameter int TIMEOUT  = 2**27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             blink_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             fast,
  output logic             stalled,
  output logic [7:0]       meas_count
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] FAST_MAX_C = CNT_W'(FAST_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT    = '1;

  state_t           state_q, state_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             period_valid_q, period_valid_d;
  logic             fast_q, fast_d;
  logic             stalled_q, stalled_d;
  logic [7:0]       meas_count_q, meas_count_d;
  logic             rise;

  // Two-flop synchronizer followed by an edge register; only rising edges matter.
  assign rise = s2_q & ~prev_q;

  // Next-state: open the window on the first rise, close/restart it on each later rise,
  // fall back to IDLE with stalled set once the window reaches TIMEOUT.
  always_comb begin
    s1_d           = blink_in;
    s2_d           = s1_q;
    prev_d         = s2_q;
    state_d        = state_q;
    cnt_d          = cnt_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    fast_d         = fast_q;
    stalled_d      = stalled_q;
    meas_count_d   = meas_count_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise) begin
          // First edge after idle only arms the window; nothing to report yet.
          cnt_d     = CNT_ONE;
          state_d   = MEASURE;
          stalled_d = 1'b0;
        end
      end
      MEASURE: begin
        if (rise) begin
          // A rise coinciding with cnt == TIMEOUT still completes a valid measurement.
          period_d       = cnt_q;
          period_valid_d = 1'b1;
          fast_d         = (cnt_q <= FAST_MAX_C);
          meas_count_d   = meas_count_q + 8'd1;
          cnt_d          = CNT_ONE;
        end else if (cnt_q == TIMEOUT_C) begin
          stalled_d = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      prev_q         <= 1'b0;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      fast_q         <= 1'b0;
      stalled_q      <= 1'b0;
      meas_count_q   <= 8'd0;
    end else begin
      state_q        <= state_d;
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      prev_q         <= prev_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      fast_q         <= fast_d;
      stalled_q      <= stalled_d;
      meas_count_q   <= meas_count_d;
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign fast         = fast_q;
  assign stalled      = stalled_q;
  assign meas_count   = meas_count_q;

endmodule
